// File: rtl/ram_arb_pkg.sv
// Shared FSM encodings and sizing helper for the RAM port arbiter.
package ram_arb_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping; purely combinational.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Clears a single-port RAM after reset, then grants one requester per cycle round-robin.
// Responses are tagged and appear exactly one cycle after the grant; no response backpressure.
import ram_arb_pkg::*;

module ram_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int RAM_SIZE = 3072,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  localparam int ID_W    = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ_VALID,
  output logic [NREQ-1:0]          REQ_READY,
  input  logic [NREQ-1:0]          REQ_WE,
  input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
  input  logic [NREQ*DATA_W-1:0]   REQ_WDATA,
  output logic                     RSP_VALID,
  output logic [ID_W-1:0]          RSP_ID,
  output logic                     RSP_WR,
  output logic                     RSP_ERR,
  output logic [DATA_W-1:0]        RSP_DATA,
  output logic                     INIT_DONE,
  output logic                     RAM_RST_N,
  output logic                     RAM_RDEN,
  output logic                     RAM_WREN,
  output logic [ADDR_W-1:0]        RAM_ADDR,
  output logic [DATA_W-1:0]        RAM_WDATA,
  input  logic [DATA_W-1:0]        RAM_RDATA
);

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic              wr;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ID_W-1:0]   ptr;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;

  logic              init_active, run, issue;
  logic              sel_we, sel_oor, ram_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              rsp_vld_q, rsp_wr_q, rsp_err_q, rsp_rd_q;
  logic [ID_W-1:0]   rsp_id_q;
  rsp_t              rsp;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(ID_W)) u_rr (
    .req   (REQ_VALID),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Everything visible is held at its reset value while RST is high.
  assign init_active = (state == ST_INIT) && !RST;
  assign run         = (state == ST_RUN) && !RST;
  assign issue       = run && gnt_any;

  assign sel_we    = REQ_WE[gnt_idx];
  assign sel_addr  = REQ_ADDR[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = REQ_WDATA[gnt_idx*DATA_W +: DATA_W];
  assign sel_oor   = ({1'b0, sel_addr} >= (ADDR_W+1)'(RAM_SIZE));
  assign ram_rd    = issue && !sel_we && !sel_oor;

  assign REQ_READY = issue ? grant : '0;
  assign INIT_DONE = run;
  assign RAM_RST_N = ~RST;
  assign RAM_RDEN  = ram_rd;
  assign RAM_WREN  = init_active || (issue && sel_we && !sel_oor);
  assign RAM_ADDR  = init_active ? clr_cnt : sel_addr;
  assign RAM_WDATA = init_active ? '0 : sel_wdata;

  // RAM read data lands in the response cycle, so the data field is muxed live.
  always_comb begin
    rsp       = '0;
    rsp.valid = rsp_vld_q && !RST;
    rsp.id    = RST ? '0 : rsp_id_q;
    rsp.wr    = rsp_wr_q && !RST;
    rsp.err   = rsp_err_q && !RST;
    rsp.data  = (rsp_rd_q && !RST) ? RAM_RDATA : '0;
  end

  assign RSP_VALID = rsp.valid;
  assign RSP_ID    = rsp.id;
  assign RSP_WR    = rsp.wr;
  assign RSP_ERR   = rsp.err;
  assign RSP_DATA  = rsp.data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      ptr       <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_wr_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      rsp_vld_q <= issue;
      rsp_id_q  <= issue ? gnt_idx : '0;
      rsp_wr_q  <= issue && sel_we;
      rsp_err_q <= issue && sel_oor;
      rsp_rd_q  <= ram_rd;
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(RAM_SIZE - 1)) state <= ST_RUN;
      end else if (issue) begin
        ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomised checks of ram_port_arbiter against a behavioural RAM and a reference model.
module tb_ram_port_arbiter;

  localparam int NREQ     = 2;
  localparam int RAM_SIZE = 3072;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic [NREQ-1:0]        REQ_VALID = '0;
  logic [NREQ-1:0]        REQ_WE = '0;
  logic [NREQ*ADDR_W-1:0] REQ_ADDR = '0;
  logic [NREQ*DATA_W-1:0] REQ_WDATA = '0;
  logic [NREQ-1:0]        REQ_READY;
  logic                   RSP_VALID, RSP_WR, RSP_ERR;
  logic [0:0]             RSP_ID;
  logic [DATA_W-1:0]      RSP_DATA;
  logic                   INIT_DONE, RAM_RST_N, RAM_RDEN, RAM_WREN;
  logic [ADDR_W-1:0]      RAM_ADDR;
  logic [DATA_W-1:0]      RAM_WDATA;
  logic [DATA_W-1:0]      RAM_RDATA;

  logic [DATA_W-1:0] mem [0:4095];
  bit                seeded = 1'b0;

  int                n_chk = 0;
  int                n_err = 0;
  int                m_ptr = 0;
  logic [DATA_W-1:0] m_mem [0:RAM_SIZE-1];
  int                g;
  int                waitc [NREQ];

  ram_port_arbiter #(.NREQ(NREQ), .RAM_SIZE(RAM_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_ID    (RSP_ID),
    .RSP_WR    (RSP_WR),
    .RSP_ERR   (RSP_ERR),
    .RSP_DATA  (RSP_DATA),
    .INIT_DONE (INIT_DONE),
    .RAM_RST_N (RAM_RST_N),
    .RAM_RDEN  (RAM_RDEN),
    .RAM_WREN  (RAM_WREN),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_WDATA (RAM_WDATA),
    .RAM_RDATA (RAM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Single-port RAM: registered read, read wins over write, OUT_DATA cleared by reset.
  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'hA5A5 ^ 16'(i);
      seeded <= 1'b1;
    end
    if (!RAM_RST_N)    RAM_RDATA <= '0;
    else if (RAM_RDEN) RAM_RDATA <= mem[RAM_ADDR];
    else if (RAM_WREN) mem[RAM_ADDR] <= RAM_WDATA;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    REQ_WE[r] = we;
    REQ_ADDR[r*ADDR_W +: ADDR_W] = a;
    REQ_WDATA[r*DATA_W +: DATA_W] = d;
  endtask

  // Called just after a rising edge; runs while RST is low and INIT_DONE is expected to rise.
  task automatic wait_init(input string tag);
    int cyc = 0;
    logic [ADDR_W-1:0] last = '0;
    #1;
    chk({tag, "_clr_wren"}, RAM_WREN, 1);
    chk({tag, "_clr_addr0"}, RAM_ADDR, 0);
    chk({tag, "_clr_wdata"}, RAM_WDATA, 0);
    while (INIT_DONE !== 1'b1 && cyc < 4000) begin
      @(posedge CLK); #1;
      cyc++;
      if (cyc == RAM_SIZE - 1) last = RAM_ADDR;
    end
    chk({tag, "_init_cycles"}, cyc, RAM_SIZE);
    chk({tag, "_clr_last_addr"}, last, RAM_SIZE - 1);
    m_ptr = 0;
    for (int i = 0; i < RAM_SIZE; i++) m_mem[i] = '0;
  endtask

  // Inputs already driven for this cycle; checks grant/issue, then the response after the edge.
  task automatic tick(output int gidx);
    logic [NREQ-1:0]   exp_rdy;
    logic              we, oor, pv, pwr, perr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd, pd;
    int                gg, pid;
    #1;
    gg = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (gg < 0 && REQ_VALID[j]) gg = j;
    end
    exp_rdy = '0;
    if (gg >= 0) exp_rdy[gg] = 1'b1;
    chk("ready", REQ_READY, exp_rdy);
    chk("one_enable", RAM_RDEN & RAM_WREN, 0);
    pv = 0; pid = 0; pwr = 0; perr = 0; pd = '0;
    if (gg >= 0) begin
      we  = REQ_WE[gg];
      a   = REQ_ADDR[gg*ADDR_W +: ADDR_W];
      wd  = REQ_WDATA[gg*DATA_W +: DATA_W];
      oor = (int'(a) >= RAM_SIZE);
      chk("rden", RAM_RDEN, !we && !oor);
      chk("wren", RAM_WREN, we && !oor);
      if (!oor) chk("ram_addr", RAM_ADDR, a);
      if (we && !oor) chk("ram_wdata", RAM_WDATA, wd);
      pv = 1; pid = gg; pwr = we; perr = oor;
      pd = (!we && !oor) ? m_mem[a] : '0;
      if (we && !oor) m_mem[a] = wd;
      m_ptr = (gg + 1) % NREQ;
    end else begin
      chk("idle_rden", RAM_RDEN, 0);
      chk("idle_wren", RAM_WREN, 0);
    end
    gidx = gg;
    @(posedge CLK); #1;
    chk("rsp_valid", RSP_VALID, pv);
    chk("rsp_id", RSP_ID, pid);
    chk("rsp_wr", RSP_WR, pwr);
    chk("rsp_err", RSP_ERR, perr);
    chk("rsp_data", RSP_DATA, pd);
  endtask

  initial begin
    // Reset with requests pending: nothing may be granted or issued.
    REQ_VALID = 2'b11;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", REQ_READY, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_rsp_id", RSP_ID, 0);
    chk("rst_rsp_wr", RSP_WR, 0);
    chk("rst_rsp_err", RSP_ERR, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_init_done", INIT_DONE, 0);
    chk("rst_rden", RAM_RDEN, 0);
    chk("rst_wren", RAM_WREN, 0);
    chk("rst_ram_rst_n", RAM_RST_N, 0);
    REQ_VALID = '0;
    RST = 1'b0;
    wait_init("boot");

    // Req0 writes 0xBEEF @5, then req1 reads @5 the very next cycle.
    set_req(0, 1'b1, 12'd5, 16'hBEEF);
    REQ_VALID = 2'b01;
    #1 chk("wr_ready", REQ_READY, 2'b01);
    tick(g);
    chk("wr_ack_wr", RSP_WR, 1);
    chk("wr_ack_data", RSP_DATA, 0);
    set_req(1, 1'b0, 12'd5, 16'h0);
    REQ_VALID = 2'b10;
    #1 chk("rd_ready", REQ_READY, 2'b10);
    tick(g);
    chk("rd_rsp_valid", RSP_VALID, 1);
    chk("rd_rsp_id", RSP_ID, 1);
    chk("rd_rsp_data", RSP_DATA, 16'hBEEF);

    // Both hold VALID: grants alternate starting from requester 0.
    set_req(0, 1'b0, 12'd100, 16'h0);
    set_req(1, 1'b0, 12'd5, 16'h0);
    REQ_VALID = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1 chk("alt_grant", REQ_READY, (i % 2) ? 2'b10 : 2'b01);
      tick(g);
      chk("alt_rsp_id", RSP_ID, i % 2);
      chk("alt_rsp_data", RSP_DATA, (i % 2) ? 16'hBEEF : 16'h0000);
    end

    // Out-of-range read and write: no RAM access, error response.
    set_req(0, 1'b0, 12'd3072, 16'h0);
    REQ_VALID = 2'b01;
    #1;
    chk("oor_rd_rden", RAM_RDEN, 0);
    chk("oor_rd_wren", RAM_WREN, 0);
    tick(g);
    chk("oor_rd_err", RSP_ERR, 1);
    chk("oor_rd_data", RSP_DATA, 0);
    set_req(1, 1'b1, 12'd4095, 16'h1234);
    REQ_VALID = 2'b10;
    #1 chk("oor_wr_wren", RAM_WREN, 0);
    tick(g);
    chk("oor_wr_err", RSP_ERR, 1);
    chk("oor_wr_wr", RSP_WR, 1);

    // Random traffic against the reference model, with a grant-wait bound.
    REQ_VALID = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!REQ_VALID[r] && $urandom_range(1, 0) == 1) begin
          set_req(r, 1'($urandom_range(1, 0)),
                  ($urandom_range(3, 0) == 0) ? 12'(3070 + $urandom_range(3, 0))
                                              : 12'($urandom_range(7, 0)),
                  16'($urandom));
          REQ_VALID[r] = 1'b1;
          waitc[r] = 0;
        end
      end
      tick(g);
      for (int r = 0; r < NREQ; r++) if (REQ_VALID[r]) waitc[r]++;
      if (g >= 0) begin
        chk("wait_bound", waitc[g] <= NREQ, 1);
        REQ_VALID[g] = 1'b0;
      end
    end

    // Reset in the cycle after a read grant: response dropped, clear restarts.
    REQ_VALID = '0;
    set_req(0, 1'b0, 12'd5, 16'h0);
    REQ_VALID = 2'b01;
    #1 chk("mid_grant", REQ_READY, 2'b01);
    @(posedge CLK); #1;
    RST = 1'b1;
    REQ_VALID = '0;
    #1;
    chk("mid_rsp_valid", RSP_VALID, 0);
    chk("mid_init_done", INIT_DONE, 0);
    @(posedge CLK); #1;
    chk("mid_rsp_valid2", RSP_VALID, 0);
    chk("mid_wren", RAM_WREN, 0);
    RST = 1'b0;
    wait_init("again");

    // Everything reads back as zero after the second clear, including the top word.
    set_req(1, 1'b0, 12'd5, 16'h0);
    REQ_VALID = 2'b10;
    tick(g);
    chk("clr_rd5", RSP_DATA, 0);
    set_req(0, 1'b0, 12'd3071, 16'h0);
    REQ_VALID = 2'b01;
    #1 chk("clr_top_rden", RAM_RDEN, 1);
    tick(g);
    chk("clr_rd3071", RSP_DATA, 0);
    chk("clr_rd3071_vld", RSP_VALID, 1);
    REQ_VALID = '0;
    tick(g);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
